// File: rtl/stream_demux.sv
// Two-way stream demultiplexer: each input word goes to a one-entry skid-free register on channel s.
// Optional per-channel output transfer counters are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [7:0]       o0_cnt,
  output logic [7:0]       o1_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [1:0]       out_ready;
  logic [1:0]       ch_valid;
  logic [1:0]       load;
  logic [1:0]       drain;
  logic [WIDTH-1:0] ch_data [2];
  logic             in_xfer;

  assign out_ready = {o1_ready, o0_ready};

  // A FULL channel whose sink is ready can drain and refill in the same cycle.
  assign i_ready = rst_n && (!ch_valid[s] || out_ready[s]);
  assign in_xfer = i_valid && i_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      state_t           state_reg;
      logic [WIDTH-1:0] data_reg;

      assign load[gi]  = in_xfer && (int'(s) == gi);
      assign drain[gi] = (state_reg == FULL) && out_ready[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (load[gi]) begin
                state_reg <= FULL;
                data_reg  <= i_data;
              end
            end
            FULL: begin
              if (load[gi]) begin
                data_reg <= i_data;
              end else if (drain[gi]) begin
                state_reg <= EMPTY;
              end
            end
            default: state_reg <= EMPTY;
          endcase
        end
      end

      assign ch_valid[gi] = (state_reg == FULL);
      assign ch_data[gi]  = data_reg;
    end
  endgenerate

  assign o0_valid = ch_valid[0];
  assign o0_data  = ch_data[0];
  assign o1_valid = ch_valid[1];
  assign o1_data  = ch_data[1];

`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] cnt [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [7:0] cnt_reg;

      // Free-running modulo-256 count of words delivered on this channel.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= 8'd0;
        end else if (drain[gi]) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end

      assign cnt[gi] = cnt_reg;
    end
  endgenerate

  assign o0_cnt = cnt[0];
  assign o1_cnt = cnt[1];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized run against a queue model.
module tb_stream_demux;

  localparam int WIDTH = 8;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             s        = 1'b0;
  logic             i_valid  = 1'b0;
  logic             i_ready;
  logic [WIDTH-1:0] i_data   = '0;
  logic             o0_valid;
  logic             o0_ready = 1'b0;
  logic [WIDTH-1:0] o0_data;
  logic             o1_valid;
  logic             o1_ready = 1'b0;
  logic [WIDTH-1:0] o1_data;
`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0]       o0_cnt;
  logic [7:0]       o1_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each channel is a FIFO of at most one word; last_n is the word most recently routed there.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;
  int         cnt0 = 0;
  int         cnt1 = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .o0_cnt   (o0_cnt),
    .o1_cnt   (o1_cnt)
`endif
  );

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = 8'h00;
    last1 = 8'h00;
    cnt0  = 0;
    cnt1  = 0;
  endtask

  function automatic logic exp_ready();
    if (s) return (q1.size() == 0) || o1_ready;
    else   return (q0.size() == 0) || o0_ready;
  endfunction

  // Predict the transfers implied by the current inputs, take one rising edge, apply them.
  task automatic model_clock();
    logic       xin, d0, d1, sel;
    logic [7:0] w;
    xin = i_valid && exp_ready();
    d0  = (q0.size() != 0) && o0_ready;
    d1  = (q1.size() != 0) && o1_ready;
    sel = s;
    w   = i_data;
    @(posedge clk);
    if (d0) begin void'(q0.pop_front()); cnt0++; end
    if (d1) begin void'(q1.pop_front()); cnt1++; end
    if (xin) begin
      if (sel) begin q1.push_back(w); last1 = w; end
      else     begin q0.push_back(w); last0 = w; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (o0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o0_valid: got %b expected 0", o0_valid); end
    n_checks++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o1_valid: got %b expected 0", o1_valid); end
    n_checks++; if (o0_data !== 8'h00) begin n_fail++; $display("FAIL reset_o0_data: got %h expected 00", o0_data); end
    n_checks++; if (o1_data !== 8'h00) begin n_fail++; $display("FAIL reset_o1_data: got %h expected 00", o1_data); end
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %b expected 0", i_ready); end
    i_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_route_single();
    s = 1'b0; i_data = 8'hA5; i_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b0;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL single_i_ready: got %b expected 1", i_ready); end
    model_clock();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o0_valid !== 1'b1 || o0_data !== 8'hA5) begin n_fail++; $display("FAIL single_o0: got v=%b d=%h expected v=1 d=a5", o0_valid, o0_data); end
    n_checks++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL single_o1_valid: got %b expected 0", o1_valid); end
    model_clock();
    #1;
    n_checks++; if (o0_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", o0_valid); end
    $display("test_route_single done");
  endtask

  task automatic test_backpressure();
    s = 1'b1; o1_ready = 1'b0; i_data = 8'h11; i_valid = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", i_ready); end
    model_clock();
    i_data = 8'h22;
    #1;
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_ready: got %b expected 0", i_ready); end
    n_checks++; if (o1_valid !== 1'b1 || o1_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold1: got v=%b d=%h expected v=1 d=11", o1_valid, o1_data); end
    model_clock();
    #1;
    n_checks++; if (o1_data !== 8'h11) begin n_fail++; $display("FAIL bp_stall_stable: got %h expected 11", o1_data); end
    o1_ready = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_refill_ready: got %b expected 1", i_ready); end
    model_clock();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o1_valid !== 1'b1 || o1_data !== 8'h22) begin n_fail++; $display("FAIL bp_second_word: got v=%b d=%h expected v=1 d=22", o1_valid, o1_data); end
    model_clock();
    #1;
    n_checks++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", o1_valid); end
    o1_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_independence();
    o0_ready = 1'b0; s = 1'b0; i_data = 8'h33; i_valid = 1'b1;
    model_clock();
    s = 1'b1; o1_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_data = 8'(k);
      #1;
      n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready_%0d: got %b expected 1", k, i_ready); end
      model_clock();
      #1;
      n_checks++; if (o1_valid !== 1'b1 || o1_data !== 8'(k)) begin n_fail++; $display("FAIL indep_o1_%0d: got v=%b d=%h expected v=1 d=%h", k, o1_valid, o1_data, 8'(k)); end
      n_checks++; if (o0_valid !== 1'b1 || o0_data !== 8'h33) begin n_fail++; $display("FAIL indep_o0_%0d: got v=%b d=%h expected v=1 d=33", k, o0_valid, o0_data); end
    end
    i_valid = 1'b0;
    model_clock();
    $display("test_independence done");
  endtask

  task automatic test_select_change();
    o0_ready = 1'b0; s = 1'b0; i_data = 8'h5A; i_valid = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL sel_stalled_ready: got %b expected 0", i_ready); end
    model_clock();
    #1;
    n_checks++; if (o0_data !== 8'h33 || o1_valid !== 1'b0) begin n_fail++; $display("FAIL sel_no_xfer: got o0_d=%h o1_v=%b expected o0_d=33 o1_v=0", o0_data, o1_valid); end
    s = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL sel_switched_ready: got %b expected 1", i_ready); end
    model_clock();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o1_valid !== 1'b1 || o1_data !== 8'h5A) begin n_fail++; $display("FAIL sel_o1: got v=%b d=%h expected v=1 d=5a", o1_valid, o1_data); end
    n_checks++; if (o0_data !== 8'h33) begin n_fail++; $display("FAIL sel_o0_hold: got %h expected 33", o0_data); end
    o0_ready = 1'b1; o1_ready = 1'b1;
    model_clock();
    model_clock();
    $display("test_select_change done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      s        = 1'($urandom_range(0, 1));
      i_valid  = ($urandom_range(0, 9) < 7);
      i_data   = 8'($urandom);
      o0_ready = ($urandom_range(0, 9) < 6);
      o1_ready = ($urandom_range(0, 9) < 6);
      #1;
      n_checks++; if (i_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_i_ready[%0d]: got %b expected %b", n, i_ready, exp_ready()); end
      n_checks++; if (o0_valid !== (q0.size() != 0) || o0_data !== last0) begin n_fail++; $display("FAIL rand_o0[%0d]: got v=%b d=%h expected v=%b d=%h", n, o0_valid, o0_data, q0.size() != 0, last0); end
      n_checks++; if (o1_valid !== (q1.size() != 0) || o1_data !== last1) begin n_fail++; $display("FAIL rand_o1[%0d]: got v=%b d=%h expected v=%b d=%h", n, o1_valid, o1_data, q1.size() != 0, last1); end
`ifdef STREAM_DEMUX_CNT_EN
      n_checks++; if (o0_cnt !== 8'(cnt0) || o1_cnt !== 8'(cnt1)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, o0_cnt, o1_cnt, 8'(cnt0), 8'(cnt1)); end
`endif
      model_clock();
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    i_valid = 1'b0; o0_ready = 1'b1; o1_ready = 1'b1;
    model_clock();
    o0_ready = 1'b0; o1_ready = 1'b0; i_valid = 1'b1;
    s = 1'b0; i_data = 8'hAA;
    model_clock();
    s = 1'b1; i_data = 8'hBB;
    model_clock();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o0_valid !== 1'b1 || o1_valid !== 1'b1) begin n_fail++; $display("FAIL mid_both_full: got %b/%b expected 1/1", o0_valid, o1_valid); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b/%b expected 0/0", o0_valid, o1_valid); end
    n_checks++; if (o0_data !== 8'h00 || o1_data !== 8'h00) begin n_fail++; $display("FAIL mid_async_data: got %h/%h expected 00/00", o0_data, o1_data); end
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL mid_i_ready: got %b expected 0", i_ready); end
    model_reset();
    @(negedge clk);
    o0_ready = 1'b1; o1_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_clock();
      #1;
      n_checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_%0d: got %b/%b expected 0/0", k, o0_valid, o1_valid); end
    end
    $display("test_reset_mid done");
  endtask

`ifdef STREAM_DEMUX_CNT_EN
  task automatic test_counter();
    n_checks++; if (o0_cnt !== 8'd0 || o1_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_start: got %0d/%0d expected 0/0", o0_cnt, o1_cnt); end
    s = 1'b0; o0_ready = 1'b1; o1_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      i_data = 8'($urandom);
      model_clock();
    end
    i_valid = 1'b0;
    model_clock();
    #1;
    n_checks++; if (cnt0 != 256 || o0_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d after %0d transfers expected 0", o0_cnt, cnt0); end
    n_checks++; if (o1_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_other: got %0d expected 0", o1_cnt); end
    $display("test_counter done");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_route_single();
    test_backpressure();
    test_independence();
    test_select_change();
    test_random();
    test_reset_mid();
`ifdef STREAM_DEMUX_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
